// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap control
// and a saturating match counter. Define SEQ_PATTERN_MASK_EN to add a don't-care mask.
module seq_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               x_in,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQ_PATTERN_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
  input  logic               clr_cnt,
  output logic               y_out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  // Only the youngest PAT_LEN-1 bits can reach a future window, so the oldest is dropped.
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
`ifdef SEQ_PATTERN_MASK_EN
  logic [PAT_LEN-1:0] mask_q, mask_d;
`endif

  logic [PAT_LEN-1:0] win;
  logic [PAT_LEN-1:0] diff;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  always_comb begin
    win    = {hist_q, x_in};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef SEQ_PATTERN_MASK_EN
    diff   = (win ^ pat_q) & ~mask_q;
`else
    diff   = win ^ pat_q;
`endif
    match  = !pat_load && x_valid && (fill_n == FILL_FULL) && (diff == '0);
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
`ifdef SEQ_PATTERN_MASK_EN
    mask_d = mask_q;
`endif

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
`ifdef SEQ_PATTERN_MASK_EN
      mask_d = pat_mask_in;
`endif
    end else if (x_valid) begin
      hist_d = win[PAT_LEN-2:0];
      if (match) begin
        fill_d = overlap ? FILL_FULL : '0;
      end else begin
        fill_d = fill_n;
      end
    end

    if (match) begin
      y_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end
    end

    // A clear coinciding with a match wins over the count; the pulse is unaffected.
    if (clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
`ifdef SEQ_PATTERN_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
`ifdef SEQ_PATTERN_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end

  assign y_out     = y_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus random
// stimulus against a queue-based reference model; two instances (CNT_W=8 and CNT_W=2).
module tb_seq_pattern_detector;

  localparam int PL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          x_in = 1'b0;
  logic          x_valid = 1'b0;
  logic          overlap = 1'b1;
  logic          pat_load = 1'b0;
  logic [PL-1:0] pat_in = '0;
  logic          clr_cnt = 1'b0;
`ifdef SEQ_PATTERN_MASK_EN
  logic [PL-1:0] pat_mask_in = '0;
`endif

  logic       y_out, cnt_sat, y_out2, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  seq_pattern_detector dut (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_PATTERN_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .clr_cnt(clr_cnt), .y_out(y_out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_pattern_detector #(.CNT_W(2)) dut_c2 (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_PATTERN_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .clr_cnt(clr_cnt), .y_out(y_out2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the sampled bits since the last restart, newest at the back.
  bit          m_bits[$];
  logic [PL-1:0] m_pat, m_mask;
  int          m_cnt, m_cnt2;
  bit          m_sat, m_sat2, m_y;

  function automatic void model_reset();
    m_bits.delete();
    m_pat  = 4'b1101;
    m_mask = '0;
    m_cnt  = 0;  m_cnt2 = 0;
    m_sat  = 0;  m_sat2 = 0;
    m_y    = 0;
  endfunction

  function automatic void count(inout int c, inout bit s, input int max_v);
    if (c < max_v) c++;
    if (c == max_v) s = 1;
  endfunction

  function automatic void model_edge();
    bit hit = 0;
    if (pat_load) begin
      m_pat = pat_in;
`ifdef SEQ_PATTERN_MASK_EN
      m_mask = pat_mask_in;
`endif
      m_bits.delete();
    end else if (x_valid) begin
      m_bits.push_back(x_in);
      if (m_bits.size() > PL) void'(m_bits.pop_front());
      if (m_bits.size() == PL) begin
        hit = 1;
        for (int i = 0; i < PL; i++)
          if (!m_mask[PL-1-i] && (m_bits[i] != m_pat[PL-1-i])) hit = 0;
      end
      if (hit && !overlap) m_bits.delete();
    end
    m_y = hit;
    if (hit) begin
      count(m_cnt, m_sat, 255);
      count(m_cnt2, m_sat2, 3);
    end
    if (clr_cnt) begin
      m_cnt = 0; m_sat = 0; m_cnt2 = 0; m_sat2 = 0;
    end
  endfunction

  task automatic check_all();
    check("y_out", y_out, m_y);
    check("match_cnt", match_cnt, m_cnt);
    check("cnt_sat", cnt_sat, m_sat);
    check("y_out_c2", y_out2, m_y);
    check("match_cnt_c2", match_cnt2, m_cnt2);
    check("cnt_sat_c2", cnt_sat2, m_sat2);
  endtask

  task automatic step(input logic xi, input logic xv, input logic pl,
                      input logic [PL-1:0] pi, input logic clr);
    @(negedge clock);
    reset    = 1'b0;
    x_in     = xi;
    x_valid  = xv;
    pat_load = pl;
    pat_in   = pi;
    clr_cnt  = clr;
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    x_valid  = 1'b0;
    pat_load = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Feed n valid bits, oldest first from bit n-1 of the vector.
  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Overlapping detection on the default pattern.
    overlap = 1'b1;
    stream(32'b1101101, 7);
    check("ovl_cnt", match_cnt, 2);

    // Non-overlapping: bits 5-7 must not complete a second match.
    do_reset();
    overlap = 1'b0;
    stream(32'b1101, 4);
    check("novl_first", y_out, 1);
    stream(32'b101, 3);
    check("novl_cnt", match_cnt, 1);

    // Gaps in the stream are transparent.
    do_reset();
    overlap = 1'b1;
    stream(32'b11, 2);
    for (int i = 0; i < 3; i++) step($urandom_range(1), 1'b0, 1'b0, '0, 1'b0);
    stream(32'b01, 2);
    check("gap_pulse", y_out, 1);

    // Reset mid-window discards the partial window.
    do_reset();
    stream(32'b110, 3);
    do_reset();
    stream(32'b1, 1);
    check("rst_mid", y_out, 0);

    // Runtime pattern load.
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    stream(32'b0110, 4);
    check("load_hit", y_out, 1);
    check("load_cnt", match_cnt, 1);
    stream(32'b1101, 4);
    check("load_old_pat", y_out, 0);

    // Saturation of the narrow counter, then a clear on a match edge.
    do_reset();
    overlap = 1'b1;
    stream(32'b1101101101, 10);
    check("sat3_cnt", match_cnt2, 3);
    check("sat3_flag", cnt_sat2, 1);
    stream(32'b101, 3);
    check("sat4_cnt", match_cnt2, 3);
    check("sat4_flag", cnt_sat2, 1);
    stream(32'b10, 2);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("clr_pulse", y_out, 1);
    check("clr_cnt", match_cnt, 0);
    check("clr_sat", cnt_sat2, 0);

`ifdef SEQ_PATTERN_MASK_EN
    pat_mask_in = 4'b0010;
    step(1'b0, 1'b1, 1'b1, 4'b1101, 1'b0);
    pat_mask_in = 4'b0000;
    stream(32'b1111, 4);
    check("mask_hit", y_out, 1);
    overlap = 1'b0;
    stream(32'b1001, 4);
    check("mask_miss", y_out, 0);
`endif

    // Drive the wide counter into saturation.
    do_reset();
    overlap = 1'b1;
    stream(32'b1, 1);
    for (int i = 0; i < 260; i++) stream(32'b101, 3);
    check("sat255_cnt", match_cnt, 255);
    check("sat255_flag", cnt_sat, 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [PL-1:0] p;
      if ($urandom_range(299) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(19) == 0) overlap = ~overlap;
      p = ($urandom_range(1) == 0) ? 4'b1101 : PL'($urandom);
`ifdef SEQ_PATTERN_MASK_EN
      pat_mask_in = ($urandom_range(1) == 0) ? '0 : PL'($urandom);
`endif
      step($urandom_range(1), ($urandom_range(4) != 0), ($urandom_range(49) == 0),
           p, ($urandom_range(39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
